// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, FSM states,
// datapath select codes and the per-opcode decode record.
package mc_cpu_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] DST_RA = 2'b00;
    localparam logic [1:0] DST_RT = 2'b01;
    localparam logic [1:0] DST_RD = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Instruction class picks the FSM path out of ID.
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LS,
        CLS_BR,
        CLS_JUMP,
        CLS_HALT
    } op_class_t;

    typedef struct packed {
        op_class_t  cls;
        logic       is_lw;
        logic       is_bne;
        logic       is_jal;
        logic [2:0] alu_op;
        logic       alu_src_b;
        logic       ext_sel;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       db_data_src;
    } decode_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multi-cycle controller (master) and the datapath
// (slave): opcode/zero flow in, datapath selects and enables flow out.
interface mc_ctrl_fsm_if;

    logic [5:0] opcode;
    logic       zero;

    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       RegWre;
    logic       WrRegDSrc;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       mRD;
    logic       mWR;
    logic       DBDataSrc;
    logic       ExtSel;
    logic [1:0] RegDst;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [2:0] state;

    modport master (
        input  opcode, zero,
        output PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB,
               mRD, mWR, DBDataSrc, ExtSel, RegDst, PCSrc, ALUOp, state
    );

    modport slave (
        output opcode, zero,
        input  PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB,
               mRD, mWR, DBDataSrc, ExtSel, RegDst, PCSrc, ALUOp, state
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Pure combinational opcode decoder: instruction class plus the
// opcode-only datapath selects. JAL decodes only with MC_CTRL_JAL_EN defined.
module mc_ctrl_decode
    import mc_cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output decode_t    dec
);

    // NOTE: every field gets a default before the case so no path leaves
    // a field unassigned, which would otherwise infer a latch.
    always_comb begin
        dec = '{cls: CLS_NOP, is_lw: 1'b0, is_bne: 1'b0, is_jal: 1'b0,
                alu_op: ALU_ADD, alu_src_b: 1'b0, ext_sel: 1'b1,
                reg_dst: DST_RT, wr_reg_d_src: 1'b1, db_data_src: 1'b0};
        case (opcode)
            OP_ADD: begin
                dec.cls     = CLS_ALU;
                dec.reg_dst = DST_RD;
            end
            OP_SUB: begin
                dec.cls     = CLS_ALU;
                dec.alu_op  = ALU_SUB;
                dec.reg_dst = DST_RD;
            end
            OP_AND: begin
                dec.cls     = CLS_ALU;
                dec.alu_op  = ALU_AND;
                dec.reg_dst = DST_RD;
            end
            OP_SLT: begin
                dec.cls     = CLS_ALU;
                dec.alu_op  = ALU_SLT;
                dec.reg_dst = DST_RD;
            end
            OP_ADDIU: begin
                dec.cls       = CLS_ALU;
                dec.alu_src_b = 1'b1;
            end
            OP_ORI: begin
                dec.cls       = CLS_ALU;
                dec.alu_op    = ALU_OR;
                dec.alu_src_b = 1'b1;
                dec.ext_sel   = 1'b0;   // logical immediate is zero-extended
            end
            OP_LW: begin
                dec.cls         = CLS_LS;
                dec.is_lw       = 1'b1;
                dec.alu_src_b   = 1'b1;
                dec.db_data_src = 1'b1;
            end
            OP_SW: begin
                dec.cls       = CLS_LS;
                dec.alu_src_b = 1'b1;
            end
            OP_BEQ: begin
                dec.cls    = CLS_BR;
                dec.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                dec.cls    = CLS_BR;
                dec.alu_op = ALU_SUB;
                dec.is_bne = 1'b1;
            end
            OP_J: begin
                dec.cls = CLS_JUMP;
            end
`ifdef MC_CTRL_JAL_EN
            OP_JAL: begin
                dec.cls          = CLS_JUMP;
                dec.is_jal       = 1'b1;
                dec.reg_dst      = DST_RA;
                dec.wr_reg_d_src = 1'b0;   // link value pc+4 instead of ALU/memory
            end
`endif
            OP_HALT: begin
                dec.cls = CLS_HALT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB). Optional JAL support is
// compiled in with MC_CTRL_JAL_EN; otherwise opcode 111010 runs as a NOP.
module mc_ctrl_fsm
    import mc_cpu_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    mc_ctrl_fsm_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    decode_t    dec;
    logic       branch_taken;
    logic       ir_wre;
    logic       pc_wre;
    logic       reg_wre;
    logic       m_rd;
    logic       m_wr;
    logic [1:0] pc_src;

    mc_ctrl_decode u_decode (
        .opcode (bus.opcode),
        .dec    (dec)
    );

    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IF;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                case (dec.cls)
                    CLS_ALU:  state_d = S_EXE_AL;
                    CLS_LS:   state_d = S_EXE_LS;
                    CLS_BR:   state_d = S_EXE_BR;
                    CLS_HALT: state_d = S_ID;
                    default:  state_d = S_IF;   // jumps and NOPs retire in ID
                endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = dec.is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    assign branch_taken = dec.is_bne ? !bus.zero : bus.zero;

    always_comb begin
        ir_wre  = 1'b0;
        pc_wre  = 1'b0;
        reg_wre = 1'b0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        pc_src  = PC_SEQ;
        case (state_q)
            S_IF: ir_wre = 1'b1;
            S_ID: begin
                case (dec.cls)
                    CLS_JUMP: begin
                        pc_wre  = 1'b1;
                        pc_src  = PC_JUMP;
                        reg_wre = dec.is_jal;
                    end
                    CLS_NOP: pc_wre = 1'b1;
                    default: ;
                endcase
            end
            S_WB_AL: begin
                pc_wre  = 1'b1;
                reg_wre = 1'b1;
            end
            S_MEM: begin
                m_rd   = dec.is_lw;
                m_wr   = !dec.is_lw;
                pc_wre = !dec.is_lw;   // SW retires here; LW still has WB_LD
            end
            S_WB_LD: begin
                pc_wre  = 1'b1;
                reg_wre = 1'b1;
            end
            S_EXE_BR: begin
                pc_wre = 1'b1;
                if (branch_taken) pc_src = PC_BRANCH;
            end
            default: ;
        endcase
    end

    // Write enables are held off for the whole reset interval, not just
    // from the moment the state register reaches IF.
    assign bus.PCWre     = pc_wre  & RST;
    assign bus.RegWre    = reg_wre & RST;
    assign bus.mRD       = m_rd    & RST;
    assign bus.mWR       = m_wr    & RST;
    assign bus.IRWre     = ir_wre;
    assign bus.InsMemRW  = ir_wre;
    assign bus.PCSrc     = pc_src;
    assign bus.ALUOp     = dec.alu_op;
    assign bus.ALUSrcA   = 1'b0;
    assign bus.ALUSrcB   = dec.alu_src_b;
    assign bus.ExtSel    = dec.ext_sel;
    assign bus.RegDst    = dec.reg_dst;
    assign bus.WrRegDSrc = dec.wr_reg_d_src;
    assign bus.DBDataSrc = dec.db_data_src;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected controls are queued
// for each instruction and compared mid-cycle against the DUT.
module tb_mc_ctrl_fsm;

    localparam logic [2:0] T_IF = 3'd0, T_ID = 3'd1, T_EXE_LS = 3'd2, T_MEM = 3'd3;
    localparam logic [2:0] T_WB_LD = 3'd4, T_EXE_BR = 3'd5, T_EXE_AL = 3'd6, T_WB_AL = 3'd7;

    localparam logic [5:0] C_ADD = 6'b000000, C_SUB = 6'b000001, C_ADDIU = 6'b000010;
    localparam logic [5:0] C_AND = 6'b010000, C_ORI = 6'b010010, C_SLT = 6'b100110;
    localparam logic [5:0] C_SW = 6'b110000, C_LW = 6'b110001, C_BEQ = 6'b110100;
    localparam logic [5:0] C_BNE = 6'b110101, C_J = 6'b111000, C_JAL = 6'b111010;
    localparam logic [5:0] C_HALT = 6'b111111;

    typedef struct packed {
        logic [2:0] state;
        logic       irwre;
        logic       insmem;
        logic       pcw;
        logic       regw;
        logic       mrd;
        logic       mwr;
        logic [1:0] pcsrc;
        logic       srca;
        logic       chk_alu;
        logic [2:0] aluop;
        logic       srcb;
        logic       ext;
        logic       chk_dst;
        logic [1:0] dst;
        logic       wrsrc;
        logic       db;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic push(input logic [2:0] s, input logic pcw, input logic regw,
                        input logic mrd, input logic mwr, input logic [1:0] pcsrc,
                        input logic ca, input logic [2:0] alu, input logic srcb, input logic ext,
                        input logic cd, input logic [1:0] dst, input logic wrsrc, input logic db);
        exp_t e;
        e.state = s;      e.irwre = (s == T_IF); e.insmem = (s == T_IF);
        e.pcw = pcw;      e.regw = regw;         e.mrd = mrd;   e.mwr = mwr;
        e.pcsrc = pcsrc;  e.srca = 1'b0;
        e.chk_alu = ca;   e.aluop = alu;         e.srcb = srcb; e.ext = ext;
        e.chk_dst = cd;   e.dst = dst;           e.wrsrc = wrsrc; e.db = db;
        sb.push_back(e);
    endtask

    task automatic push_ctl(input logic [2:0] s, input logic pcw, input logic regw,
                            input logic mrd, input logic mwr, input logic [1:0] pcsrc);
        push(s, pcw, regw, mrd, mwr, pcsrc, 1'b0, 3'b0, 1'b0, 1'b0, 1'b0, 2'b0, 1'b0, 1'b0);
    endtask

    // Fields the expectation marks as don't-care are copied from it.
    function automatic exp_t observe(input exp_t e);
        exp_t a;
        a.state = bus.state;  a.irwre = bus.IRWre;  a.insmem = bus.InsMemRW;
        a.pcw = bus.PCWre;    a.regw = bus.RegWre;  a.mrd = bus.mRD;  a.mwr = bus.mWR;
        a.pcsrc = bus.PCSrc;  a.srca = bus.ALUSrcA;
        a.chk_alu = e.chk_alu;
        a.aluop = e.chk_alu ? bus.ALUOp   : e.aluop;
        a.srcb  = e.chk_alu ? bus.ALUSrcB : e.srcb;
        a.ext   = e.chk_alu ? bus.ExtSel  : e.ext;
        a.chk_dst = e.chk_dst;
        a.dst   = e.chk_dst ? bus.RegDst    : e.dst;
        a.wrsrc = e.chk_dst ? bus.WrRegDSrc : e.wrsrc;
        a.db    = e.chk_dst ? bus.DBDataSrc : e.db;
        return a;
    endfunction

    // Queues the expected per-cycle controls for one instruction, drives it
    // and compares each cycle. Entered and left mid-cycle with state IF.
    task automatic run_instr(input string name, input logic [5:0] op, input logic z);
        logic [2:0] alu;
        logic       srcb, ext, taken;
        logic [1:0] dst;
        exp_t       e, a;
        int         step = 0;
        push_ctl(T_IF, 0, 0, 0, 0, 2'b00);
        case (op)
            C_ADD, C_SUB, C_AND, C_SLT, C_ADDIU, C_ORI: begin
                alu = 3'b000; srcb = 1'b0; ext = 1'b1; dst = 2'b10;
                case (op)
                    C_SUB:   alu = 3'b001;
                    C_AND:   alu = 3'b100;
                    C_SLT:   alu = 3'b110;
                    C_ADDIU: begin srcb = 1'b1; dst = 2'b01; end
                    C_ORI:   begin alu = 3'b011; srcb = 1'b1; ext = 1'b0; dst = 2'b01; end
                    default: ;
                endcase
                push_ctl(T_ID, 0, 0, 0, 0, 2'b00);
                push(T_EXE_AL, 0, 0, 0, 0, 2'b00, 1, alu, srcb, ext, 0, 2'b0, 0, 0);
                push(T_WB_AL, 1, 1, 0, 0, 2'b00, 0, 3'b0, 0, 0, 1, dst, 1, 0);
            end
            C_LW: begin
                push_ctl(T_ID, 0, 0, 0, 0, 2'b00);
                push(T_EXE_LS, 0, 0, 0, 0, 2'b00, 1, 3'b000, 1, 1, 0, 2'b0, 0, 0);
                push_ctl(T_MEM, 0, 0, 1, 0, 2'b00);
                push(T_WB_LD, 1, 1, 0, 0, 2'b00, 0, 3'b0, 0, 0, 1, 2'b01, 1, 1);
            end
            C_SW: begin
                push_ctl(T_ID, 0, 0, 0, 0, 2'b00);
                push(T_EXE_LS, 0, 0, 0, 0, 2'b00, 1, 3'b000, 1, 1, 0, 2'b0, 0, 0);
                push_ctl(T_MEM, 1, 0, 0, 1, 2'b00);
            end
            C_BEQ, C_BNE: begin
                taken = (op == C_BEQ) ? z : !z;
                push_ctl(T_ID, 0, 0, 0, 0, 2'b00);
                push(T_EXE_BR, 1, 0, 0, 0, taken ? 2'b01 : 2'b00, 1, 3'b001, 0, 1, 0, 2'b0, 0, 0);
            end
            C_J: push_ctl(T_ID, 1, 0, 0, 0, 2'b10);
`ifdef MC_CTRL_JAL_EN
            C_JAL: push(T_ID, 1, 1, 0, 0, 2'b10, 0, 3'b0, 0, 0, 1, 2'b00, 0, 0);
`endif
            C_HALT: for (int i = 0; i < 10; i++) push_ctl(T_ID, 0, 0, 0, 0, 2'b00);
            default: push_ctl(T_ID, 1, 0, 0, 0, 2'b00);
        endcase
        bus.opcode = op;
        bus.zero   = z;
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            a = observe(e);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s step %0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                         name, step, a.state, a, e.state, e);
            end
            step++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #3;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.opcode = C_ADD;
        bus.zero = 1'b0;
        #2;
        checks++;
        if (bus.state !== T_IF || {bus.PCWre, bus.RegWre, bus.mRD, bus.mWR} !== 4'b0) begin
            failures++;
            $display("FAIL reset_state: got state=%0d en=%b, expected state=0 en=0000",
                     bus.state, {bus.PCWre, bus.RegWre, bus.mRD, bus.mWR});
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (bus.state !== T_IF) begin
            failures++;
            $display("FAIL reset_hold: got state=%0d, expected 0", bus.state);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_alu();
        run_instr("add",   C_ADD,   1'b0);
        run_instr("sub",   C_SUB,   1'b1);
        run_instr("and",   C_AND,   1'b0);
        run_instr("slt",   C_SLT,   1'b0);
        run_instr("addiu", C_ADDIU, 1'b0);
        run_instr("ori",   C_ORI,   1'b1);
    endtask

    task automatic test_load_store();
        run_instr("lw", C_LW, 1'b0);
        run_instr("sw", C_SW, 1'b0);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", C_BEQ, 1'b1);
        run_instr("beq_z0", C_BEQ, 1'b0);
        run_instr("bne_z1", C_BNE, 1'b1);
        run_instr("bne_z0", C_BNE, 1'b0);
    endtask

    task automatic test_jump();
        run_instr("j",   C_J,   1'b0);
        run_instr("jal", C_JAL, 1'b0);
    endtask

    task automatic test_nop();
        run_instr("nop_03", 6'b000011, 1'b0);
        run_instr("nop_2a", 6'b101010, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [12] = '{C_ADD, C_SUB, C_ADDIU, C_AND, C_ORI, C_SLT,
                                 C_SW, C_LW, C_BEQ, C_BNE, C_J, C_JAL};
        for (int i = 0; i < 20; i++)
            run_instr("b2b", ops[$urandom_range(0, 11)], 1'($urandom_range(0, 1)));
    endtask

    task automatic test_halt();
        run_instr("halt", C_HALT, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state !== T_IF || bus.PCWre !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset: got state=%0d PCWre=%b, expected state=0 PCWre=0",
                     bus.state, bus.PCWre);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset_midop();
        bus.opcode = C_ADD;
        bus.zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.state !== T_WB_AL || bus.RegWre !== 1'b1) begin
            failures++;
            $display("FAIL midop_wb_al: got state=%0d RegWre=%b, expected state=7 RegWre=1",
                     bus.state, bus.RegWre);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state !== T_IF || bus.RegWre !== 1'b0 || bus.PCWre !== 1'b0) begin
            failures++;
            $display("FAIL midop_async: got state=%0d RegWre=%b PCWre=%b, expected 0 0 0",
                     bus.state, bus.RegWre, bus.PCWre);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== T_ID) begin
            failures++;
            $display("FAIL midop_restart: got state=%0d, expected 1", bus.state);
        end
        apply_reset();
        bus.opcode = C_SW;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.state !== T_MEM || bus.mWR !== 1'b1) begin
            failures++;
            $display("FAIL midop_mem: got state=%0d mWR=%b, expected state=3 mWR=1",
                     bus.state, bus.mWR);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state !== T_IF || bus.mWR !== 1'b0 || bus.mRD !== 1'b0) begin
            failures++;
            $display("FAIL midop_mem_abort: got state=%0d mWR=%b mRD=%b, expected 0 0 0",
                     bus.state, bus.mWR, bus.mRD);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jump();
        test_nop();
        test_back_to_back();
        test_halt();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, FSM advances on posedge.
REQ-002 SHALL have ports: RST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: opcode  in  6  instruction bits [31:26] from instruction register.
REQ-004 SHALL have ports: zero  in  1  ALU zero flag from EXE cycle.
REQ-005 SHALL have ports: PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, mRD, mWR, DBDataSrc, ExtSel  out  1 each  datapath controls.
REQ-006 SHALL have ports: RegDst  out  2  00=$31, 01=rt, 10=rd; PCSrc  out  2  00=pc+4, 01=pc+4+(imm<<2), 10=jump target.
REQ-007 SHALL have ports: ALUOp  out  3  000 add, 001 sub, 011 or, 100 and, 110 slt; state  out  3  current state, for debug.

Function
REQ-008 SHALL decode opcodes ADD 000000, SUB 000001, ADDIU 000010, AND 010000, ORI 010010, SLT 100110, SW 110000, LW 110001, BEQ 110100, BNE 110101, J 111000, JAL 111010, HALT 111111.
REQ-009 SHALL implement states IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111, registered on posedge CLK.
REQ-010 SHALL transition IF->ID unconditionally; ID->EXE_AL for ALU ops, EXE_LS for LW/SW, EXE_BR for BEQ/BNE, IF for J/JAL, ID (hold) for HALT.
REQ-011 SHALL transition EXE_AL->WB_AL->IF; EXE_LS->MEM; MEM->WB_LD for LW, MEM->IF for SW; WB_LD->IF; EXE_BR->IF.
REQ-012 SHALL drive all outputs combinationally from state register and opcode only, stable across negedge CLK so the register file's negedge write samples settled controls.
REQ-013 SHALL assert IRWre=1 and InsMemRW=1 in IF only.
REQ-014 SHALL assert PCWre=1 only in final cycle of each instruction: ID for J/JAL, WB_AL, EXE_BR, MEM for SW, WB_LD; never for HALT.
REQ-015 SHALL assert RegWre=1 only in WB_AL, WB_LD, and ID for JAL.
REQ-016 SHALL drive RegDst=10 for R-type ALU ops, 01 for ADDIU/ORI/LW, 00 for JAL; WrRegDSrc=0 for JAL, 1 otherwise.
REQ-017 SHALL assert mRD=1 in MEM for LW, mWR=1 in MEM for SW; DBDataSrc=1 for LW, 0 otherwise.
REQ-018 SHALL drive ALUSrcB=1 for ADDIU/ORI/LW/SW; ExtSel=0 for ORI, 1 otherwise; ALUSrcA=0.
REQ-019 SHALL drive PCSrc=01 in EXE_BR when (BEQ and zero=1) or (BNE and zero=0), 10 in ID for J/JAL, 00 otherwise.
REQ-020 SHALL treat undefined opcodes as NOP: ID->IF, PCWre=1, PCSrc=00, no register or memory write.

Reset
REQ-021 SHALL on RST=0 immediately force state=IF; all write enables (PCWre, RegWre, mWR, mRD) SHALL be 0 while RST=0 regardless of state.
REQ-022 SHALL abort an in-flight instruction on reset mid-operation with no register or memory write; first post-reset posedge enters ID.

Configuration
REQ-023 SHALL compile JAL support only when macro MC_CTRL_JAL_EN is defined; without it, opcode 111010 SHALL follow REQ-020 (NOP).

Structure
REQ-024 SHALL place opcode constants, state encodings, ALUOp, RegDst and PCSrc encodings in shared package mc_cpu_pkg.
REQ-025 SHALL split next-state/state register from a combinational sub-module mc_ctrl_decode producing per-opcode class signals.

Verification
REQ-026 ADD after reset -> states IF,ID,EXE_AL,WB_AL,IF; RegWre=1 and RegDst=10 only in WB_AL; PCWre=1 only in WB_AL.
REQ-027 LW -> 5 states ending WB_LD; mRD=1 in MEM; WB_LD RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1.
REQ-028 BEQ zero=1 -> EXE_BR PCSrc=01, PCWre=1; BNE zero=1 -> PCSrc=00.
REQ-029 JAL with MC_CTRL_JAL_EN -> ID RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=10; without macro -> RegWre=0, PCSrc=00.
REQ-030 HALT -> state holds 001, PCWre=0 for 10 cycles; RST=0 during WB_AL -> state=000 asynchronously, RegWre=0.
